uart_rx_cmd_fifo: RTL
=====================

Name: uart_rx_cmd_fifo

Overview:
Receive-side stage between the UART byte receiver and DMI_UART_TAP. Decodes the escape-framed byte stream into data bytes and command bytes. Buffers the results in a show-ahead FIFO and presents them on the TAP's receive interface (DATA_REC, RX_EMPTY, CMD_REC, READ). This decouples UART line rate from TAP consumption.

Parameters:
DEPTH, 16, FIFO entries; must be a power of 2 and at least 2
ESC_CHAR, uart_pkg::ESC_CHAR (8'hB1), escape byte that prefixes a command byte

Ports:
CLK_I  in  1  system clock
RST_NI  in  1  synchronous active-low reset, sampled on rising CLK_I
RX_BYTE_I  in  8  byte from the UART receiver
RX_VALID_I  in  1  one-cycle strobe; RX_BYTE_I is valid
READ_I  in  1  pop request from the TAP (its READ_O)
DATA_REC_O  out  8  head-entry byte
CMD_REC_O  out  1  head entry is a command byte
RX_EMPTY_O  out  1  FIFO empty
FILL_O  out  $clog2(DEPTH)+1  number of occupied entries
OVERFLOW_O  out  1  sticky: a decoded byte was dropped because the FIFO was full
CLR_OVF_I  in  1  clears OVERFLOW_O

Behaviour:
- Reset (RST_NI=0 at a rising edge):
  - read and write pointers = 0; FILL_O = 0; RX_EMPTY_O = 1.
  - DATA_REC_O = 0, CMD_REC_O = 0, OVERFLOW_O = 0.
  - Decoder returns to IDLE.
  - Reset applies even mid-escape or while the FIFO is full; no entry survives it.
- Decoder FSM, states IDLE and ESCAPED. Transitions only on RX_VALID_I=1:
  - IDLE, byte == ESC_CHAR -> ESCAPED; nothing pushed.
  - IDLE, other byte -> push {cmd=0, byte}; stay in IDLE.
  - ESCAPED, byte == ESC_CHAR -> push {cmd=0, ESC_CHAR}, i.e. a literal escape; go to IDLE.
  - ESCAPED, other byte -> push {cmd=1, byte}; go to IDLE.
  - Decoder is a single registered state bit; the push happens in the same cycle as RX_VALID_I.
- FIFO storage:
  - Each entry is 9 bits: {cmd, data}.
  - Pointers are $clog2(DEPTH)+1 bits wide. Empty when the pointers are equal. Full when the MSBs differ and the remaining bits are equal. Wrap-around is natural modulo 2*DEPTH.
- Show-ahead output:
  - When RX_EMPTY_O=0, DATA_REC_O and CMD_REC_O show the head entry combinationally from the storage and read pointer.
  - When empty they drive 0.
- Push to an empty FIFO: RX_EMPTY_O falls on the cycle after the push. Write-to-visible latency is 1 clock.
- Pop: READ_I=1 with RX_EMPTY_O=0 advances the read pointer at the edge. The next entry is visible the following cycle. READ_I while empty is ignored; pointers and FILL_O are unchanged.
- Push while full, without a pop in the same cycle:
  - the entry is dropped;
  - OVERFLOW_O is set from the next cycle;
  - FIFO contents are unchanged;
  - the decoder state still advances.
- Simultaneous push and pop:
  - Both take effect in the same cycle and FILL_O is unchanged.
  - This includes the full case: the pop frees a slot, the push is accepted, and there is no overflow.
  - For an empty FIFO with simultaneous push and pop, the pop is ignored and the push is accepted.
- OVERFLOW_O:
  - Cleared by CLR_OVF_I=1 at the next edge.
  - If CLR_OVF_I and a new overflow occur in the same cycle, the set wins.
- FILL_O is a registered count that always equals write pointer minus read pointer, in the range 0..DEPTH.

Decomposition:
- uart_pkg gains ESC_CHAR (8'hB1). It also gains the typedef rx_entry_t = struct packed {logic cmd; logic [7:0] data;} and the enum rx_dec_state_t {DEC_IDLE, DEC_ESCAPED}.
- One natural sub-module: sync_fifo, parameterised by WIDTH and DEPTH, with show-ahead output, full/empty flags and fill count. It is instantiated with WIDTH=9. The decoder FSM and overflow logic stay in the top module.

Test Plan:
1. Reset, then bytes 0x01, 0x02, 0x03 with no READ_I -> FILL_O=3, RX_EMPTY_O=0. Head shows DATA_REC_O=0x01, CMD_REC_O=0. Three READ_I pulses return 0x02 then 0x03, then RX_EMPTY_O=1.
2. Bytes 0xB1, 0x12 (escape + CMD_READ/ADDR_IDCODE) -> a single entry with CMD_REC_O=1, DATA_REC_O=0x12, FILL_O=1.
3. Bytes 0xB1, 0xB1, 0x05 -> two entries: {cmd=0, 0xB1}, then {cmd=0, 0x05}; decoder back in IDLE.
4. Push 17 data bytes with DEPTH=16 and no reads -> FILL_O=16, OVERFLOW_O=1, and the 17th byte is absent. Then pulse CLR_OVF_I -> OVERFLOW_O=0.
5. With the FIFO full, drive RX_VALID_I and READ_I in the same cycle -> FILL_O stays 16, OVERFLOW_O stays 0, and the head advances. Also cover pointer wrap-around: more than 32 push/pop pairs with data matching in order.
6. Send 0xB1, then assert RST_NI=0 for one cycle, then send 0x12 -> entry {cmd=0, 0x12}, proving the escape was cleared. FIFO empty immediately after reset. READ_I while empty leaves FILL_O=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the receive-side command/data entry types.
package uart_pkg;
  localparam logic [7:0] ESC_CHAR = 8'hB1;
  typedef struct packed {
    logic       cmd;
    logic [7:0] data;
  } rx_entry_t;
  typedef enum logic {DEC_IDLE, DEC_ESCAPED} rx_dec_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with full/empty flags and a registered fill count.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_fill
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr, r_rd, r_fill;
  logic             w_wr, w_rd;
  always_comb begin
    o_empty = r_wr == r_rd;
    o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    w_rd    = i_pop && !o_empty;
    // a same-cycle pop frees the slot the push lands in, so full never blocks it
    w_wr    = i_push && (!o_full || w_rd);
    o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
    o_fill  = r_fill;
  end
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
    end else begin
      r_wr   <= r_wr + PW'(w_wr);
      r_rd   <= r_rd + PW'(w_rd);
      r_fill <= r_fill + PW'(w_wr) - PW'(w_rd);
    end
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/uart_rx_cmd_fifo.sv
// uart_rx_cmd_fifo: splits the escape-framed UART byte stream into data/command entries
// and buffers them in a show-ahead FIFO for the TAP receive interface.
module uart_rx_cmd_fifo #(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] ESC_CHAR = uart_pkg::ESC_CHAR
) (
  input  logic                     CLK_I,
  input  logic                     RST_NI,
  input  logic [7:0]               RX_BYTE_I,
  input  logic                     RX_VALID_I,
  input  logic                     READ_I,
  output logic [7:0]               DATA_REC_O,
  output logic                     CMD_REC_O,
  output logic                     RX_EMPTY_O,
  output logic [$clog2(DEPTH):0]   FILL_O,
  output logic                     OVERFLOW_O,
  input  logic                     CLR_OVF_I
);
  uart_pkg::rx_dec_state_t r_state, w_state_nxt;
  uart_pkg::rx_entry_t     w_entry, w_head;
  logic                    w_push, w_full, w_is_esc, w_drop, r_ovf;
  always_comb begin
    w_is_esc      = RX_BYTE_I == ESC_CHAR;
    w_push        = RX_VALID_I && !(r_state == uart_pkg::DEC_IDLE && w_is_esc);
    w_entry.cmd   = r_state == uart_pkg::DEC_ESCAPED && !w_is_esc;
    w_entry.data  = RX_BYTE_I;
    w_state_nxt   = !RX_VALID_I ? r_state :
                    (r_state == uart_pkg::DEC_IDLE && w_is_esc) ? uart_pkg::DEC_ESCAPED :
                    uart_pkg::DEC_IDLE;
    // when full the FIFO is non-empty, so READ_I alone decides whether a slot frees up
    w_drop        = w_push && w_full && !READ_I;
  end
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      r_state <= uart_pkg::DEC_IDLE;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ovf   <= w_drop ? 1'b1 : CLR_OVF_I ? 1'b0 : r_ovf;
    end
  end
  sync_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_fifo (
    .clk     (CLK_I),
    .i_rst_n (RST_NI),
    .i_push  (w_push),
    .i_pop   (READ_I),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_empty (RX_EMPTY_O),
    .o_full  (w_full),
    .o_fill  (FILL_O)
  );
  assign DATA_REC_O = w_head.data;
  assign CMD_REC_O  = w_head.cmd;
  assign OVERFLOW_O = r_ovf;
endmodule
